// File: rtl/muldiv_pkg.sv
// Shared definitions for the muldiv unit (shift multiplier and shift divider).
// Contents: FSM state encoding, operand widths, special-case constants and
// the W-form extension helper. No ports.
// The divider's optional early-out path is enabled by the macro DIV_EARLY_OUT_EN.
package muldiv_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned WLEN  = 32;
    localparam int unsigned CNT_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;
    localparam logic [XLEN-1:0] INT_MIN64  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [WLEN-1:0] INT_MIN32  = {1'b1, {(WLEN-1){1'b0}}};

    // Widen a 32-bit W-form value to XLEN, sign- or zero-extending.
    function automatic logic [XLEN-1:0] wext(input logic [WLEN-1:0] v, input logic sgn);
        return sgn ? {{(XLEN-WLEN){v[WLEN-1]}}, v} : {{(XLEN-WLEN){1'b0}}, v};
    endfunction

endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negation: res_o = neg_i ? -val_i : val_i.
// Used for operand magnitudes and for the final sign fix of the divider.
// Ports:
//   val_i  XLEN  input value
//   neg_i  1     negate when 1
//   res_o  XLEN  result (combinational)
module div_abs_neg
    import muldiv_pkg::*;
(
    input  logic [XLEN-1:0] val_i,
    input  logic            neg_i,
    output logic [XLEN-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + XLEN'(1)) : val_i;

endmodule

// File: rtl/div_shift_64clk.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per CALC cycle; quotient and remainder produced together.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   div_valid, div_ready  request handshake (ready == idle)
//   flush                 abort current operation, priority over accept
//   divw, div_signed      W-form select, signed select
//   dividend, divisor     operands (latched at accept)
//   out_valid             one-cycle result pulse
//   quotient, remainder   results, held until the next completion
// Optional: define DIV_EARLY_OUT_EN to skip CALC for divide-by-zero, signed
// overflow and |dividend| < |divisor|.
module div_shift_64clk
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            div_valid,
    input  logic            flush,
    input  logic            divw,
    input  logic            div_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            div_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dsr_q, dsr_d;
    logic [XLEN-1:0]  dvd_q, dvd_d;
    logic [XLEN-1:0]  quotient_q, quotient_d;
    logic [XLEN-1:0]  remainder_q, remainder_d;
    logic             w_q, w_d;
    logic             sq_q, sq_d;
    logic             sr_q, sr_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;

    logic [XLEN-1:0]  a_eff_c, b_eff_c, a_mag_c, b_mag_c, a_dvd_c;
    logic             a_neg_c, b_neg_c, dz_c, ovf_c, accept_c;
    logic [XLEN:0]    shl_c, diff_c;
    logic [XLEN-1:0]  rem_nx_c, quo_nx_c, q_fix_c, r_fix_c, res_q_c, res_r_c;
    logic [CNT_W-1:0] n_c, cnt_inc_c;

    // Effective operands and special-case detection from the live inputs.
    always_comb begin
        a_eff_c = divw ? wext(dividend[WLEN-1:0], div_signed) : dividend;
        b_eff_c = divw ? wext(divisor[WLEN-1:0], div_signed)  : divisor;
        // Reported dividend is always sign-extended in W-form, even unsigned.
        a_dvd_c = divw ? wext(dividend[WLEN-1:0], 1'b1) : dividend;
        a_neg_c = div_signed & a_eff_c[XLEN-1];
        b_neg_c = div_signed & b_eff_c[XLEN-1];
        dz_c    = (b_eff_c == '0);
        ovf_c   = div_signed && (b_eff_c == '1) &&
                  (a_eff_c == (divw ? wext(INT_MIN32, 1'b1) : INT_MIN64));
    end

    div_abs_neg u_abs_a (.val_i(a_eff_c), .neg_i(a_neg_c), .res_o(a_mag_c));
    div_abs_neg u_abs_b (.val_i(b_eff_c), .neg_i(b_neg_c), .res_o(b_mag_c));

`ifdef DIV_EARLY_OUT_EN
    logic lt_c;
    assign lt_c = (a_mag_c < b_mag_c);
`endif

    assign accept_c = div_valid & ready_q & ~flush;

    // One restoring step: shift {rem, quo} left, trial-subtract in XLEN+1 bits.
    always_comb begin
        shl_c    = {rem_q, quo_q[XLEN-1]};
        diff_c   = shl_c - {1'b0, dsr_q};
        rem_nx_c = diff_c[XLEN] ? shl_c[XLEN-1:0] : diff_c[XLEN-1:0];
        quo_nx_c = {quo_q[XLEN-2:0], ~diff_c[XLEN]};
    end

    // Sign fix operates on the final step's output so DONE follows the last step.
    div_abs_neg u_fix_q (.val_i(quo_nx_c), .neg_i(sq_q), .res_o(q_fix_c));
    div_abs_neg u_fix_r (.val_i(rem_nx_c), .neg_i(sr_q), .res_o(r_fix_c));

    // Final result selection, special cases override the iterated value.
    always_comb begin
        if (dz_q) begin
            res_q_c = DIV_ZERO_Q;
            res_r_c = dvd_q;
        end else if (ovf_q) begin
            res_q_c = dvd_q;
            res_r_c = '0;
        end else if (w_q) begin
            res_q_c = wext(q_fix_c[WLEN-1:0], 1'b1);
            res_r_c = wext(r_fix_c[WLEN-1:0], 1'b1);
        end else begin
            res_q_c = q_fix_c;
            res_r_c = r_fix_c;
        end
    end

    assign n_c       = w_q ? CNT_W'(WLEN) : CNT_W'(XLEN);
    assign cnt_inc_c = cnt_q + CNT_W'(1);

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        dvd_d       = dvd_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        w_d         = w_q;
        sq_d        = sq_q;
        sr_d        = sr_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        valid_d     = 1'b0;

        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        w_d     = divw;
                        sq_d    = a_neg_c ^ b_neg_c;
                        sr_d    = a_neg_c;
                        dz_d    = dz_c;
                        ovf_d   = ovf_c;
                        dvd_d   = a_dvd_c;
                        dsr_d   = b_mag_c;
                        rem_d   = '0;
                        // W-form dividend sits in the top half so 32 steps consume it.
                        quo_d   = divw ? {a_mag_c[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : a_mag_c;
                        cnt_d   = '0;
                        state_d = CALC;
`ifdef DIV_EARLY_OUT_EN
                        if (dz_c || ovf_c || lt_c) begin
                            state_d     = DONE;
                            valid_d     = 1'b1;
                            quotient_d  = dz_c ? DIV_ZERO_Q : (ovf_c ? a_dvd_c : '0);
                            remainder_d = ovf_c ? '0 : a_dvd_c;
                        end
`endif
                    end
                end
                CALC: begin
                    rem_d = rem_nx_c;
                    quo_d = quo_nx_c;
                    cnt_d = cnt_inc_c;
                    if (cnt_inc_c == n_c) begin
                        state_d     = DONE;
                        valid_d     = 1'b1;
                        quotient_d  = res_q_c;
                        remainder_d = res_r_c;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            dvd_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            w_q         <= 1'b0;
            sq_q        <= 1'b0;
            sr_q        <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            dvd_q       <= dvd_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            w_q         <= w_d;
            sq_q        <= sq_d;
            sr_q        <= sr_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
        end
    end

    // A flush arriving during DONE still suppresses the result pulse.
    assign out_valid = valid_q & ~flush;
    assign div_ready = ready_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_div_shift_64clk.sv
module tb_div_shift_64clk;

    logic        clk = 1'b0;
    logic        rst, div_valid, flush, divw, div_signed;
    logic [63:0] dividend, divisor, quotient, remainder;
    logic        div_ready, out_valid;

    int total = 0;
    int bad   = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    always #5 clk = ~clk;

    div_shift_64clk dut (
        .clk       (clk),
        .rst       (rst),
        .div_valid (div_valid),
        .flush     (flush),
        .divw      (divw),
        .div_signed(div_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .div_ready (div_ready),
        .out_valid (out_valid),
        .quotient  (quotient),
        .remainder (remainder)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V division semantics via native arithmetic.
    function automatic void model(input bit w, input bit s, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] q,
                                  output logic [63:0] r, output bit early);
        logic [31:0] a32, b32, q32, r32, ma32, mb32;
        logic [63:0] ma, mb;
        int          sa32, sb32;
        longint      sa, sb;
        a32  = a[31:0];
        b32  = b[31:0];
        ma32 = (s && a32[31]) ? -a32 : a32;
        mb32 = (s && b32[31]) ? -b32 : b32;
        ma   = (s && a[63]) ? -a : a;
        mb   = (s && b[63]) ? -b : b;
        if (w) begin
            if (b32 == 32'd0) begin
                q32 = '1; r32 = a32; early = 1'b1;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = '0; early = 1'b1;
            end else if (s) begin
                sa32 = a32; sb32 = b32;
                q32 = sa32 / sb32; r32 = sa32 % sb32; early = (ma32 < mb32);
            end else begin
                q32 = a32 / b32; r32 = a32 % b32; early = (ma32 < mb32);
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) begin
                q = '1; r = a; early = 1'b1;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = '0; early = 1'b1;
            end else if (s) begin
                sa = a; sb = b;
                q = sa / sb; r = sa % sb; early = (ma < mb);
            end else begin
                q = a / b; r = a % b; early = (ma < mb);
            end
        end
    endfunction

    // Issue one request from an idle DUT and check latency, results and hold.
    task automatic run_op(input string tag, input bit w, input bit s,
                          input logic [63:0] a, input logic [63:0] b);
        logic [63:0] eq, er;
        bit          early;
        int          exp_lat, lat;
        model(w, s, a, b, eq, er, early);
        exp_lat = (EARLY && early) ? 1 : (w ? 33 : 65);
        chk($sformatf("%s_ready_in", tag), 64'(div_ready), 64'd1);
        divw = w; div_signed = s; dividend = a; divisor = b; div_valid = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        // scramble inputs while busy: operands must be latched, requests ignored
        div_valid = 1'($urandom); dividend = {$urandom, $urandom};
        divisor = {$urandom, $urandom}; divw = 1'($urandom); div_signed = 1'($urandom);
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            div_valid = 1'($urandom);
        end
        div_valid = 1'b0;
        chk($sformatf("%s_latency", tag), 64'(lat), 64'(exp_lat));
        chk($sformatf("%s_q", tag), quotient, eq);
        chk($sformatf("%s_r", tag), remainder, er);
        @(posedge clk); #1;
        chk($sformatf("%s_pulse_end", tag), 64'(out_valid), 64'd0);
        chk($sformatf("%s_ready_out", tag), 64'(div_ready), 64'd1);
        chk($sformatf("%s_q_hold", tag), quotient, eq);
    endtask

    initial begin
        bit          seen, w, s;
        logic [63:0] a, b;

        rst = 1'b1; div_valid = 1'b0; flush = 1'b0; divw = 1'b0; div_signed = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 64'(div_ready), 64'd1);
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_q", quotient, 64'd0);
        chk("reset_r", remainder, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("s20_3", 1'b0, 1'b1, 64'd20, 64'd3);
        chk("s20_3_q_const", quotient, 64'd6);
        chk("s20_3_r_const", remainder, 64'd2);
        run_op("sm20_3", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
        chk("sm20_3_q_const", quotient, 64'hFFFF_FFFF_FFFF_FFFA);
        chk("sm20_3_r_const", remainder, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("um20_3", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
        chk("um20_3_q_const", quotient, 64'h5555_5555_5555_554E);
        run_op("dz_s", 1'b0, 1'b1, 64'h1234, 64'd0);
        chk("dz_s_q_const", quotient, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("dz_s_r_const", remainder, 64'h1234);
        run_op("dz_u", 1'b0, 1'b0, 64'h1234, 64'd0);
        run_op("ovf64", 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ovf64_q_const", quotient, 64'h8000_0000_0000_0000);
        run_op("ovfw", 1'b1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF);
        chk("ovfw_q_const", quotient, 64'hFFFF_FFFF_8000_0000);
        chk("ovfw_r_const", remainder, 64'd0);
        run_op("wu_half", 1'b1, 1'b0, 64'hDEAD_BEEF_FFFF_FFFF, 64'd2);
        chk("wu_half_q_const", quotient, 64'h0000_0000_7FFF_FFFF);
        chk("wu_half_r_const", remainder, 64'd1);
        run_op("wu_one", 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFE, 64'd1);
        chk("wu_one_q_const", quotient, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("small_lt", 1'b0, 1'b1, 64'd5, 64'hFFFF_FFFF_FFFF_FFF9);

        // flush ten cycles into CALC
        divw = 1'b0; div_signed = 1'b1; dividend = 64'd100; divisor = 64'd7; div_valid = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_calc_ready", 64'(div_ready), 64'd1);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("flush_calc_no_valid", 64'(seen), 64'd0);
        run_op("after_flush", 1'b0, 1'b1, 64'd100, 64'd7);
        chk("after_flush_q_const", quotient, 64'd14);
        chk("after_flush_r_const", remainder, 64'd2);

        // flush in the DONE cycle suppresses the pulse
        divw = 1'b1; div_signed = 1'b0; dividend = 64'd100; divisor = 64'd7; div_valid = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        chk("done_reached", 64'(out_valid), 64'd1);
        flush = 1'b1;
        #1;
        chk("flush_done_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_done_ready", 64'(div_ready), 64'd1);
        chk("flush_done_after", 64'(out_valid), 64'd0);

        // flush wins over accept
        div_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0; flush = 1'b0;
        chk("flush_prio_ready", 64'(div_ready), 64'd1);

        // reset mid-CALC clears the outputs
        run_op("pre_rst", 1'b0, 1'b0, 64'd1000, 64'd9);
        divw = 1'b0; div_signed = 1'b1; dividend = 64'd20; divisor = 64'd3; div_valid = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_q", quotient, 64'd0);
        chk("rst_mid_r", remainder, 64'd0);
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_ready", 64'(div_ready), 64'd1);
        rst = 1'b0;
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("rst_mid_no_valid", 64'(seen), 64'd0);

        // randomized operations against the model
        for (int i = 0; i < 30; i++) begin
            w = 1'($urandom);
            s = 1'($urandom);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: b = 64'($urandom_range(0, 3));
                1: b = b >> $urandom_range(1, 62);
                2: begin
                    a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
                    b = '1;
                end
                3: a = a >> $urandom_range(0, 63);
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), w, s, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
